// File: rtl/z80fi_recorder.sv
// z80fi retirement recorder: assembles one record per instruction
// from per-T-state core events and publishes it as a one-cycle pulse.
module z80fi_recorder #(
  parameter int MCYCLE_W    = 3,
  parameter int MAX_MCYCLES = 6,
  parameter int TCYC_W      = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                insn_start,
  input  logic                mcycle_start,
  input  logic [MCYCLE_W-1:0] mcycle_type,
  input  logic                opcode_byte_valid,
  input  logic [7:0]          opcode_byte,
  input  logic                mem_rd,
  input  logic                mem_wr,
  input  logic [15:0]         mem_addr,
  input  logic [7:0]          mem_data,
  input  logic                insn_done,
  output logic                z80fi_valid,
  output logic [31:0]         z80fi_insn,
  output logic [2:0]          z80fi_insn_len,
  output logic [15:0]         z80fi_bus_raddr,
  output logic [15:0]         z80fi_bus_raddr2,
  output logic [7:0]          z80fi_bus_rdata,
  output logic [7:0]          z80fi_bus_rdata2,
  output logic [15:0]         z80fi_bus_waddr,
  output logic [15:0]         z80fi_bus_waddr2,
  output logic [7:0]          z80fi_bus_wdata,
  output logic [7:0]          z80fi_bus_wdata2,
  output logic                z80fi_mem_rd,
  output logic                z80fi_mem_rd2,
  output logic                z80fi_mem_wr,
  output logic                z80fi_mem_wr2,
  output logic [MCYCLE_W-1:0] z80fi_mcycle_type1,
  output logic [MCYCLE_W-1:0] z80fi_mcycle_type2,
  output logic [MCYCLE_W-1:0] z80fi_mcycle_type3,
  output logic [MCYCLE_W-1:0] z80fi_mcycle_type4,
  output logic [MCYCLE_W-1:0] z80fi_mcycle_type5,
  output logic [MCYCLE_W-1:0] z80fi_mcycle_type6,
  output logic [TCYC_W-1:0]   z80fi_tcycles1,
  output logic [TCYC_W-1:0]   z80fi_tcycles2,
  output logic [TCYC_W-1:0]   z80fi_tcycles3,
  output logic [TCYC_W-1:0]   z80fi_tcycles4,
  output logic [TCYC_W-1:0]   z80fi_tcycles5,
  output logic [TCYC_W-1:0]   z80fi_tcycles6,
  output logic                z80fi_overflow
);

  localparam int SW = $clog2(MAX_MCYCLES + 1);
  localparam logic [SW-1:0]     SLOTS = SW'(MAX_MCYCLES);
  localparam logic [SW-1:0]     SONE  = SW'(1);
  localparam logic [TCYC_W-1:0] TONE  = TCYC_W'(1);
  localparam logic [TCYC_W-1:0] TMAX  = '1;

  typedef enum logic {IDLE, REC} state_t;

  typedef struct packed {
    logic [31:0] insn;
    logic [2:0]  len;
    logic [15:0] raddr;
    logic [15:0] raddr2;
    logic [7:0]  rdata;
    logic [7:0]  rdata2;
    logic [15:0] waddr;
    logic [15:0] waddr2;
    logic [7:0]  wdata;
    logic [7:0]  wdata2;
    logic        rd;
    logic        rd2;
    logic        wr;
    logic        wr2;
    logic [MAX_MCYCLES-1:0][MCYCLE_W-1:0] mtype;
    logic [MAX_MCYCLES-1:0][TCYC_W-1:0]   tcyc;
    logic [SW-1:0] nslot;
    logic          mstop;
    logic          ovf;
  } rec_t;

  state_t state_q, state_d;
  rec_t   acc_q, acc_d, out_q, ret_d;
  logic   valid_q;
  logic   retire, acc_we;
  logic [SW-1:0] cur;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (insn_start) state_d = REC;
      REC:  if (insn_done && !insn_start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A retiring record shares no events with a coincident new one.
  always_comb begin
    retire = (state_q == REC) && insn_done;
    acc_we = (state_q == REC) || insn_start;
    ret_d  = insn_start ? acc_q : acc_d;
  end

  always_comb begin
    acc_d = insn_start ? '0 : acc_q;
    cur   = acc_d.nslot - SONE;
    if (insn_start || mcycle_start) begin
      if (acc_d.nslot == SLOTS) begin
        acc_d.mstop = 1'b1;
        acc_d.ovf   = 1'b1;
      end else begin
        acc_d.mtype[acc_d.nslot] = mcycle_type;
        acc_d.tcyc[acc_d.nslot]  = TONE;
        acc_d.nslot = acc_d.nslot + SONE;
      end
    end else if (acc_d.nslot != '0 && !acc_d.mstop) begin
      if (acc_d.tcyc[cur] == TMAX) acc_d.ovf = 1'b1;
      else acc_d.tcyc[cur] = acc_d.tcyc[cur] + TONE;
    end
    if (opcode_byte_valid) begin
      if (acc_d.len == 3'd4) begin
        acc_d.ovf = 1'b1;
      end else begin
        acc_d.insn[{acc_d.len[1:0], 3'b000} +: 8] = opcode_byte;
        acc_d.len = acc_d.len + 3'd1;
      end
    end
    if (mem_rd) begin
      if (!acc_d.rd) begin
        acc_d.rd    = 1'b1;
        acc_d.raddr = mem_addr;
        acc_d.rdata = mem_data;
      end else if (!acc_d.rd2) begin
        acc_d.rd2    = 1'b1;
        acc_d.raddr2 = mem_addr;
        acc_d.rdata2 = mem_data;
      end else begin
        acc_d.ovf = 1'b1;
      end
    end
    if (mem_wr) begin
      if (!acc_d.wr) begin
        acc_d.wr    = 1'b1;
        acc_d.waddr = mem_addr;
        acc_d.wdata = mem_data;
      end else if (!acc_d.wr2) begin
        acc_d.wr2    = 1'b1;
        acc_d.waddr2 = mem_addr;
        acc_d.wdata2 = mem_data;
      end else begin
        acc_d.ovf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (acc_we) acc_q <= acc_d;
      if (retire) out_q <= ret_d;
      valid_q <= retire;
    end
  end

  assign z80fi_valid        = valid_q;
  assign z80fi_insn         = out_q.insn;
  assign z80fi_insn_len     = out_q.len;
  assign z80fi_bus_raddr    = out_q.raddr;
  assign z80fi_bus_raddr2   = out_q.raddr2;
  assign z80fi_bus_rdata    = out_q.rdata;
  assign z80fi_bus_rdata2   = out_q.rdata2;
  assign z80fi_bus_waddr    = out_q.waddr;
  assign z80fi_bus_waddr2   = out_q.waddr2;
  assign z80fi_bus_wdata    = out_q.wdata;
  assign z80fi_bus_wdata2   = out_q.wdata2;
  assign z80fi_mem_rd       = out_q.rd;
  assign z80fi_mem_rd2      = out_q.rd2;
  assign z80fi_mem_wr       = out_q.wr;
  assign z80fi_mem_wr2      = out_q.wr2;
  assign z80fi_mcycle_type1 = out_q.mtype[0];
  assign z80fi_mcycle_type2 = out_q.mtype[1];
  assign z80fi_mcycle_type3 = out_q.mtype[2];
  assign z80fi_mcycle_type4 = out_q.mtype[3];
  assign z80fi_mcycle_type5 = out_q.mtype[4];
  assign z80fi_mcycle_type6 = out_q.mtype[5];
  assign z80fi_tcycles1     = out_q.tcyc[0];
  assign z80fi_tcycles2     = out_q.tcyc[1];
  assign z80fi_tcycles3     = out_q.tcyc[2];
  assign z80fi_tcycles4     = out_q.tcyc[3];
  assign z80fi_tcycles5     = out_q.tcyc[4];
  assign z80fi_tcycles6     = out_q.tcyc[5];
  assign z80fi_overflow     = out_q.ovf;

endmodule
